// File: rtl/sync_mem_pkg.sv
// Shared types and helpers for the synchronous two-port memory.
package sync_mem_pkg;

    typedef enum logic {INIT, RUN} mem_state_t;

    localparam int BYTE_W = 8;

    function automatic int nb(input int w);
        return w / BYTE_W;
    endfunction

endpackage

// File: rtl/sync_mem_rd_pipe.sv
// Read-result pipeline: one or two register stages carrying valid and data.
module sync_mem_rd_pipe #(
    parameter int W      = 32,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [W-1:0] data_in,
    output logic         vld_out,
    output logic [W-1:0] data_out
);

    logic         vld_p0;
    logic [W-1:0] data_p0;

    // Stage p0: capture the array word at the accept edge; data holds between results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= vld_in;
            if (vld_in) data_p0 <= data_in;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic         vld_p1;
            logic [W-1:0] data_p1;

            // Stage p1: plain retiming register on both valid and data
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) data_p1 <= data_p0;
                end
            end

            assign vld_out  = vld_p1;
            assign data_out = data_p1;
        end else begin : g_lat1
            assign vld_out  = vld_p0;
            assign data_out = data_p0;
        end
    endgenerate

endmodule

// File: rtl/sync_mem_2p.sv
// Synchronous two-port memory: byte-enabled write port, pipelined read port,
// self-clearing init sweep after reset.
module sync_mem_2p
    import sync_mem_pkg::*;
#(
    parameter int           W       = 32,
    parameter int           A       = 4,
    parameter int           RD_LAT  = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [A-1:0]      wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [nb(W)-1:0]  wr_be,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [A-1:0]      rd_addr,
    output logic              rd_valid,
    output logic [W-1:0]      rd_data,
    output logic              busy
);

    localparam int NB    = nb(W);
    localparam int DEPTH = 2 ** A;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("sync_mem_2p: RD_LAT must be 1 or 2");
        end
        if (W % BYTE_W != 0) begin : g_bad_w
            $error("sync_mem_2p: W must be a multiple of 8");
        end
    endgenerate

    logic [W-1:0] mem [DEPTH];
    mem_state_t   state;
    logic [A-1:0] cnt;
    logic         wr_fire;
    logic         rd_fire;

    assign wr_fire = wr_req && (state == RUN);
    assign rd_fire = rd_req && (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INIT;
            cnt    <= '0;
            busy   <= 1'b1;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= wr_fire;
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == {A{1'b1}}) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN:     busy  <= 1'b0;
                default: state <= INIT;
            endcase
        end
    end

    // The sweep owns the array until RUN; afterwards only the write port updates it
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= CLR_VAL;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array is read before this edge's write lands, so a same-address read sees old data
    sync_mem_rd_pipe #(
        .W      (W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (rd_fire),
        .data_in  (mem[rd_addr]),
        .vld_out  (rd_valid),
        .data_out (rd_data)
    );

endmodule

// File: tb/tb_sync_mem_2p.sv
// Directed bench for sync_mem_2p; two instances (RD_LAT=1 and 2) share stimulus.
module tb_sync_mem_2p;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_req;
    logic [3:0]  rd_addr;

    logic        wr_ack1, rd_valid1, busy1;
    logic [31:0] rd_data1;
    logic        wr_ack2, rd_valid2, busy2;
    logic [31:0] rd_data2;

    int checks = 0;
    int errors = 0;

    sync_mem_2p #(.W(32), .A(4), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack1),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .busy(busy1)
    );

    sync_mem_2p #(.W(32), .A(4), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack2),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid2), .rd_data(rd_data2),
        .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_cycles;
        rst = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_req = 1'b0; rd_addr = '0;
        tick(); tick();
        checks++;
        if (busy1 !== 1'b1 || wr_ack1 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got busy=%b ack=%b vld=%b data=%h want 1 0 0 0",
                     busy1, wr_ack1, rd_valid1, rd_data1);
        end
        // Requests held through the whole sweep must be ignored
        wr_req = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_req = 1'b1; rd_addr = 4'd0;
        rst = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 40 && busy1 === 1'b1; k++) begin
            busy_cycles++;
            if (wr_ack1 !== 1'b0 || rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL sweep_quiet cycle %0d got ack=%b vld=%b/%b want 0", k,
                         wr_ack1, rd_valid1, rd_valid2);
            end
            tick();
        end
        checks++;
        if (busy_cycles !== 16) begin
            errors++;
            $display("FAIL sweep_len got %0d want 16", busy_cycles);
        end
        checks++;
        if (wr_ack1 !== 1'b0 || rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL sweep_last got ack=%b vld=%b want 0 0", wr_ack1, rd_valid1);
        end
        wr_req = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
                errors++;
                $display("FAIL clear_read addr %0d got vld=%b data=%h want 1 00000000",
                         a, rd_valid1, rd_data1);
            end
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_byte_enable();
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
        tick();
        checks++;
        if (wr_ack1 !== 1'b1) begin
            errors++;
            $display("FAIL be_ack1 got %b want 1", wr_ack1);
        end
        wr_data = 32'h11223344; wr_be = 4'b0101;
        tick();
        checks++;
        if (wr_ack1 !== 1'b1) begin
            errors++;
            $display("FAIL be_ack2 got %b want 1", wr_ack1);
        end
        wr_req = 1'b0;
        rd_req = 1'b1; rd_addr = 4'd3;
        tick();
        checks++;
        if (wr_ack1 !== 1'b0) begin
            errors++;
            $display("FAIL be_ack_drop got %b want 0", wr_ack1);
        end
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL be_read got vld=%b data=%h want 1 aa22cc44", rd_valid1, rd_data1);
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_valid1 !== 1'b0 || rd_data1 !== 32'hAA22CC44) begin
            errors++;
            $display("FAIL rd_hold got vld=%b data=%h want 0 aa22cc44", rd_valid1, rd_data1);
        end
    endtask

    task automatic test_collision();
        wr_req = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_req = 1'b1; rd_addr = 4'd5;
        tick();
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL collide_old got vld=%b data=%h want 1 00000000", rd_valid1, rd_data1);
        end
        wr_req = 1'b0;
        tick();
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL collide_new got vld=%b data=%h want 1 deadbeef", rd_valid1, rd_data1);
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_be_zero();
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 32'h5; wr_be = 4'hF;
        tick();
        wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
        tick();
        checks++;
        if (wr_ack1 !== 1'b1) begin
            errors++;
            $display("FAIL be0_ack got %b want 1", wr_ack1);
        end
        wr_req = 1'b0;
        rd_req = 1'b1; rd_addr = 4'd7;
        tick();
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h5) begin
            errors++;
            $display("FAIL be0_read got vld=%b data=%h want 1 00000005", rd_valid1, rd_data1);
        end
        rd_req = 1'b0;
        tick();
    endtask

    task automatic test_stream_lat2();
        logic [31:0] exp_data;
        wr_req = 1'b1; wr_be = 4'hF;
        for (int a = 0; a < 4; a++) begin
            wr_addr = 4'(a);
            wr_data = 32'h10 + 32'(a);
            tick();
        end
        wr_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                rd_req = 1'b1;
                rd_addr = 4'(k);
            end else begin
                rd_req = 1'b0;
            end
            tick();
            checks++;
            if (rd_valid2 !== (k >= 1 && k <= 4)) begin
                errors++;
                $display("FAIL stream2_vld step %0d got %b want %b", k, rd_valid2, (k >= 1 && k <= 4));
            end
            if (k >= 1 && k <= 4) begin
                exp_data = 32'h10 + 32'(k - 1);
                checks++;
                if (rd_data2 !== exp_data) begin
                    errors++;
                    $display("FAIL stream2_data step %0d got %h want %h", k, rd_data2, exp_data);
                end
            end
            checks++;
            if (rd_valid1 !== (k <= 3)) begin
                errors++;
                $display("FAIL stream1_vld step %0d got %b want %b", k, rd_valid1, (k <= 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        int busy_cycles;
        wr_req = 1'b1; wr_addr = 4'd9; wr_data = 32'h99; wr_be = 4'hF;
        tick();
        wr_data = 32'h55;
        rd_req = 1'b1; rd_addr = 4'd9;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_valid2 !== 1'b0 || rd_data2 !== 32'h0 || rd_data1 !== 32'h0 || rd_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_read got vld=%b/%b data=%h/%h want 0 0 0 0",
                     rd_valid1, rd_valid2, rd_data1, rd_data2);
        end
        checks++;
        if (wr_ack1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ctrl got ack=%b busy=%b want 0 1", wr_ack1, busy1);
        end
        tick();
        checks++;
        if (rd_valid2 !== 1'b0 || rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL midrst_hold got vld=%b data=%h want 0 0", rd_valid2, rd_data2);
        end
        tick();
        rst = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 40 && busy1 === 1'b1; k++) begin
            busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles !== 16) begin
            errors++;
            $display("FAIL resweep_len got %0d want 16", busy_cycles);
        end
        rd_req = 1'b1; rd_addr = 4'd9;
        tick();
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL resweep_9 got vld=%b data=%h want 1 00000000", rd_valid1, rd_data1);
        end
        rd_addr = 4'd3;
        tick();
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL resweep_3 got vld=%b data=%h want 1 00000000", rd_valid1, rd_data1);
        end
        rd_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_collision();
        test_be_zero();
        test_stream_lat2();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_mem_2p.md
Name: sync_mem_2p

Overview:
- Parametrised synchronous two-port memory that succeeds the lab's asynchronous strobe-driven single-port RAM.
- Provides one write port with byte enables and one independent read port with configurable registered read latency.
- Clears itself on power-up through an init sweep, reporting busy while the sweep runs.
- Used as the storage element behind lab interface and task/function benches, wherever a clocked memory with a valid handshake is needed.

Parameters:
W, 32, data width in bits; must be a multiple of 8; NB = W/8 byte lanes
A, 4, address width; depth = 2**A words
RD_LAT, 1, read latency in clock cycles; legal values 1 or 2; any other value is an elaboration error
CLR_VAL, '0, W-bit value written to every word during the init sweep

Ports:
clk  input  1  single clock, all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
wr_req  input  1  write request, sampled each cycle
wr_addr  input  A  write address
wr_data  input  W  write data
wr_be  input  NB  byte enables; bit i covers wr_data[8i+7:8i]
wr_ack  output  1  one-cycle pulse, the cycle after a write is accepted
rd_req  input  1  read request, sampled each cycle
rd_addr  input  A  read address
rd_valid  output  1  high for one cycle when rd_data carries a result
rd_data  output  W  read data; holds its last value while rd_valid is low
busy  output  1  high during the init sweep; all requests are ignored while high

Behaviour:
- Reset values while rst is high, applied asynchronously: wr_ack=0, rd_valid=0, rd_data=0, busy=1, state=INIT, sweep counter=0, read pipeline valid bits cleared. Memory contents are not reset directly.
- FSM states: INIT and RUN.
- INIT: one word per cycle, mem[cnt] <= CLR_VAL, cnt increments.
  - The cycle that writes word 2**A-1 moves the FSM to RUN.
  - busy goes low on the first RUN cycle, exactly 2**A cycles after rst deasserts.
- INIT request handling: wr_req and rd_req are ignored. No ack or valid is generated, and requests are not queued.
- RUN: the FSM stays in RUN until rst.
- Write, accepted when wr_req=1 in RUN:
  - For every i with wr_be[i]=1, byte lane i of mem[wr_addr] is updated at that clock edge.
  - Lanes with wr_be[i]=0 are unchanged.
  - wr_ack=1 in the next cycle only.
  - wr_be=0 still acks and changes no data.
  - Back-to-back writes give back-to-back acks.
- Read, accepted when rd_req=1 in RUN:
  - mem[rd_addr] is sampled at the accept edge.
  - rd_valid and rd_data appear RD_LAT cycles after the accept cycle.
  - The pipeline is fully pipelined: one read per cycle, in order, with no stalls.
- Read and write to the same address in the same cycle: the read returns the old (pre-write) contents. The write takes effect for subsequent reads.
- Write and read to different addresses in the same cycle: fully independent.
- RD_LAT=2: the extra stage is a plain register stage on both data and valid.
- rst asserted mid-operation:
  - In-flight reads are discarded and rd_valid drops immediately.
  - A pending wr_ack is dropped.
  - The FSM returns to INIT and a fresh sweep runs after deassertion.
- Address range: the full range is always legal because depth is exactly 2**A. There is no wrap or out-of-range case.

Decomposition:
- Package sync_mem_pkg:
  - typedef enum logic {INIT, RUN} mem_state_t
  - localparam for byte-lane width (8)
  - function nb(W) returning W/8
- Sub-module sync_mem_rd_pipe, parametrised by W and RD_LAT: carries valid+data through the 1- or 2-stage read pipeline with async reset of the valid bits. The top instantiates it once.
- Storage array, write logic and FSM stay in the top.

Test Plan (W=32, A=4, RD_LAT=1 unless stated):
- Init sweep: pulse rst, then hold wr_req=1 and rd_req=1 from deassertion -> busy=1 for exactly 16 cycles and no wr_ack/rd_valid during that time; first reads after busy falls return 32'h0 for addresses 0..15.
- Byte-enable write: write 32'hAABBCCDD to addr 3 with be=4'hF, then 32'h11223344 with be=4'b0101 -> read addr 3 gives 32'hAA22CC44; wr_ack pulses one cycle after each write.
- Collision: mem[5]=32'h0; in one cycle write 32'hDEADBEEF be=F to addr 5 and read addr 5 -> rd_data=32'h0; a read the next cycle gives 32'hDEADBEEF.
- Streaming reads with RD_LAT=2: preload addr0..3 with 0x10..0x13, issue reads on 4 consecutive cycles -> rd_valid high on 4 consecutive cycles starting 2 cycles after the first request, data 0x10,0x11,0x12,0x13 in order.
- Reset mid-read: issue a read, assert rst on the next edge before the result returns -> rd_valid stays 0 and rd_data=0; busy=1; after deassertion the sweep repeats and earlier data is cleared to CLR_VAL.
- wr_be=0: write 32'hFFFFFFFF be=0 to addr 7 holding 32'h5 -> wr_ack still pulses and a read returns 32'h5.
